// File: rtl/core_dbg_regs.sv
// rtl/core_dbg_regs.sv - debug control/status register slave with core register bridge
module core_dbg_regs #(
  parameter int          ADDR_WIDTH    = 5,
  parameter int          DATA_WIDTH    = 32,
  parameter int          NR_BP         = 2,
  parameter int          REG_IDX_WIDTH = 5,
  parameter int          ACK_TIMEOUT   = 255,
  parameter logic [31:0] DBG_ID        = 32'h0DBC0001
) (
  input  logic                        memi_clk,
  input  logic                        memi_rst,
  input  logic                        memi_sel,
  input  logic [ADDR_WIDTH-1:0]       memi_addr,
  input  logic                        memi_wr_rd,
  input  logic [DATA_WIDTH-1:0]       memi_wdata,
  output logic [DATA_WIDTH-1:0]       memi_rdata,
  output logic                        memi_ready,
  input  logic                        core_halted,
  input  logic                        bp_hit,
  output logic                        halt_req,
  output logic                        resume_pulse,
  output logic                        step_pulse,
  output logic [NR_BP-1:0]            bp_en,
  output logic [NR_BP*DATA_WIDTH-1:0] bp_addr,
  output logic                        core_reg_req,
  output logic                        core_reg_wr,
  output logic [REG_IDX_WIDTH-1:0]    core_reg_idx,
  output logic [DATA_WIDTH-1:0]       core_reg_wdata,
  input  logic [DATA_WIDTH-1:0]       core_reg_rdata,
  input  logic                        core_reg_ack
);

  typedef enum logic [1:0] {IDLE, CORE, RESP, WAIT_DESEL} state_t;

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  localparam logic [ADDR_WIDTH-1:0] A_ID       = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_BP_EN    = ADDR_WIDTH'(3);
  localparam int                    A_BP_BASE  = 4;
  localparam logic [ADDR_WIDTH-1:0] A_GPR_IDX  = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] A_GPR_DATA = ADDR_WIDTH'(9);

  state_t                      state_q, state_d;
  logic                        halt_req_q, halt_req_d;
  logic                        resume_q, resume_d;
  logic                        step_q, step_d;
  logic [NR_BP-1:0]            bp_en_q, bp_en_d;
  logic [NR_BP*DATA_WIDTH-1:0] bp_addr_q, bp_addr_d;
  logic                        bp_sticky_q, bp_sticky_d;
  logic                        err_q, err_d;
  logic [REG_IDX_WIDTH-1:0]    gpr_idx_q, gpr_idx_d;
  logic                        req_q, req_d;
  logic                        wr_q, wr_d;
  logic [REG_IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
  logic                        ready_q, ready_d;
  logic [DATA_WIDTH-1:0]       rd_val;

  // Read mux for the plain register map; unmapped addresses read as zero
  always_comb begin
    rd_val = '0;
    case (memi_addr)
      A_ID:      rd_val = DATA_WIDTH'(DBG_ID);
      A_CTRL:    rd_val = DATA_WIDTH'(halt_req_q);
      A_STATUS:  rd_val = DATA_WIDTH'({err_q, bp_sticky_q, core_halted});
      A_BP_EN:   rd_val = DATA_WIDTH'(bp_en_q);
      A_GPR_IDX: rd_val = DATA_WIDTH'(gpr_idx_q);
      default:   rd_val = '0;
    endcase
    for (int i = 0; i < NR_BP; i++) begin
      if (memi_addr == ADDR_WIDTH'(A_BP_BASE + i)) begin
        rd_val = bp_addr_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Access FSM and register next-state; pulses, ready and rdata default to zero each cycle
  always_comb begin
    state_d     = state_q;
    halt_req_d  = halt_req_q;
    resume_d    = 1'b0;
    step_d      = 1'b0;
    bp_en_d     = bp_en_q;
    bp_addr_d   = bp_addr_q;
    bp_sticky_d = bp_sticky_q;
    err_d       = err_q;
    gpr_idx_d   = gpr_idx_q;
    req_d       = req_q;
    wr_d        = wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = '0;
    ready_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (memi_sel) begin
          if (memi_addr == A_GPR_DATA && core_halted) begin
            state_d = CORE;
            req_d   = 1'b1;
            wr_d    = memi_wr_rd;
            idx_d   = gpr_idx_q;
            wdata_d = memi_wr_rd ? memi_wdata : '0;
            cnt_d   = '0;
          end else begin
            state_d = RESP;
            ready_d = 1'b1;
            if (memi_addr == A_GPR_DATA) begin
              err_d = 1'b1;
            end else if (!memi_wr_rd) begin
              rdata_d = rd_val;
            end else begin
              case (memi_addr)
                A_CTRL: begin
                  if (memi_wdata[0]) halt_req_d = 1'b1;
                  // resume takes priority over step when both are requested
                  if (memi_wdata[1]) begin
                    if (core_halted) begin
                      halt_req_d = 1'b0;
                      resume_d   = 1'b1;
                    end else begin
                      err_d = 1'b1;
                    end
                  end else if (memi_wdata[2]) begin
                    if (core_halted) step_d = 1'b1;
                    else             err_d  = 1'b1;
                  end
                end
                A_STATUS: begin
                  if (memi_wdata[1]) bp_sticky_d = 1'b0;
                  if (memi_wdata[2]) err_d       = 1'b0;
                end
                A_BP_EN:   bp_en_d   = memi_wdata[NR_BP-1:0];
                A_GPR_IDX: gpr_idx_d = memi_wdata[REG_IDX_WIDTH-1:0];
                default: begin
                  for (int i = 0; i < NR_BP; i++) begin
                    if (memi_addr == ADDR_WIDTH'(A_BP_BASE + i)) begin
                      bp_addr_d[i*DATA_WIDTH +: DATA_WIDTH] = memi_wdata;
                    end
                  end
                end
              endcase
            end
          end
        end
      end
      CORE: begin
        if (core_reg_ack || cnt_q == CNT_LAST) begin
          state_d = RESP;
          ready_d = 1'b1;
          req_d   = 1'b0;
          wr_d    = 1'b0;
          idx_d   = '0;
          wdata_d = '0;
          cnt_d   = '0;
          if (core_reg_ack) begin
            rdata_d = wr_q ? '0 : core_reg_rdata;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: state_d = WAIT_DESEL;
      WAIT_DESEL: begin
        if (!memi_sel) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // a breakpoint hit beats a same-cycle clear of the sticky bit
    if (bp_hit) bp_sticky_d = 1'b1;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge memi_clk or negedge memi_rst) begin
    if (!memi_rst) begin
      state_q     <= IDLE;
      halt_req_q  <= 1'b0;
      resume_q    <= 1'b0;
      step_q      <= 1'b0;
      bp_en_q     <= '0;
      bp_addr_q   <= '0;
      bp_sticky_q <= 1'b0;
      err_q       <= 1'b0;
      gpr_idx_q   <= '0;
      req_q       <= 1'b0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_req_q  <= halt_req_d;
      resume_q    <= resume_d;
      step_q      <= step_d;
      bp_en_q     <= bp_en_d;
      bp_addr_q   <= bp_addr_d;
      bp_sticky_q <= bp_sticky_d;
      err_q       <= err_d;
      gpr_idx_q   <= gpr_idx_d;
      req_q       <= req_d;
      wr_q        <= wr_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
    end
  end

  assign memi_rdata     = rdata_q;
  assign memi_ready     = ready_q;
  assign halt_req       = halt_req_q;
  assign resume_pulse   = resume_q;
  assign step_pulse     = step_q;
  assign bp_en          = bp_en_q;
  assign bp_addr        = bp_addr_q;
  assign core_reg_req   = req_q;
  assign core_reg_wr    = wr_q;
  assign core_reg_idx   = idx_q;
  assign core_reg_wdata = wdata_q;

endmodule

// File: tb/tb_core_dbg_regs.sv
// tb/tb_core_dbg_regs.sv - self-checking bench for core_dbg_regs
module tb_core_dbg_regs;

  localparam int          AW  = 5;
  localparam int          DW  = 32;
  localparam int          NBP = 2;
  localparam int          IW  = 5;
  localparam int          AT  = 20;
  localparam logic [31:0] ID  = 32'h0DBC0001;

  logic             memi_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             memi_sel = 1'b0;
  logic [AW-1:0]    memi_addr = '0;
  logic             memi_wr_rd = 1'b0;
  logic [DW-1:0]    memi_wdata = '0;
  logic [DW-1:0]    memi_rdata;
  logic             memi_ready;
  logic             core_halted = 1'b0;
  logic             bp_hit = 1'b0;
  logic             halt_req, resume_pulse, step_pulse;
  logic [NBP-1:0]   bp_en;
  logic [NBP*DW-1:0] bp_addr;
  logic             core_reg_req, core_reg_wr;
  logic [IW-1:0]    core_reg_idx;
  logic [DW-1:0]    core_reg_wdata;
  logic [DW-1:0]    core_reg_rdata = '0;
  logic             core_reg_ack = 1'b0;

  core_dbg_regs #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_BP(NBP), .REG_IDX_WIDTH(IW),
    .ACK_TIMEOUT(AT), .DBG_ID(ID)
  ) dut (
    .memi_clk(memi_clk), .memi_rst(rst_n), .memi_sel(memi_sel), .memi_addr(memi_addr),
    .memi_wr_rd(memi_wr_rd), .memi_wdata(memi_wdata), .memi_rdata(memi_rdata),
    .memi_ready(memi_ready), .core_halted(core_halted), .bp_hit(bp_hit),
    .halt_req(halt_req), .resume_pulse(resume_pulse), .step_pulse(step_pulse),
    .bp_en(bp_en), .bp_addr(bp_addr), .core_reg_req(core_reg_req),
    .core_reg_wr(core_reg_wr), .core_reg_idx(core_reg_idx),
    .core_reg_wdata(core_reg_wdata), .core_reg_rdata(core_reg_rdata),
    .core_reg_ack(core_reg_ack)
  );

  always #5 memi_clk = ~memi_clk;

  int checks = 0;
  int errors = 0;

  // reference model of the architectural register state
  logic           m_halt, m_err, m_bp;
  logic [NBP-1:0] m_bp_en;
  logic [31:0]    m_bp_addr [NBP];
  logic [IW-1:0]  m_gpr_idx;

  // core-side responder bookkeeping
  int          ack_delay = 0;
  int          req_cycles = 0;
  int          last_req_len = 0;
  logic [IW-1:0] idx_seen;
  logic        wr_seen;
  logic [31:0] wdata_seen;
  bit          unstable = 0;

  int resume_cnt = 0, step_cnt = 0, ready_cnt = 0;

  always @(negedge memi_clk) begin
    if (resume_pulse) resume_cnt = resume_cnt + 1;
    if (step_pulse)   step_cnt   = step_cnt + 1;
    if (memi_ready)   ready_cnt  = ready_cnt + 1;
  end

  always @(negedge memi_clk) begin
    if (core_reg_req) begin
      req_cycles = req_cycles + 1;
      if (req_cycles == 1) begin
        idx_seen   = core_reg_idx;
        wr_seen    = core_reg_wr;
        wdata_seen = core_reg_wdata;
      end else if (idx_seen !== core_reg_idx || wr_seen !== core_reg_wr ||
                   wdata_seen !== core_reg_wdata) begin
        unstable = 1;
      end
      core_reg_ack = (ack_delay != 0 && req_cycles == ack_delay);
    end else begin
      if (req_cycles != 0) last_req_len = req_cycles;
      req_cycles   = 0;
      core_reg_ack = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_halt = 0; m_err = 0; m_bp = 0; m_bp_en = '0; m_gpr_idx = '0;
    for (int i = 0; i < NBP; i++) m_bp_addr[i] = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd0:    return ID;
      5'd1:    return {31'b0, m_halt};
      5'd2:    return {29'b0, m_err, m_bp, core_halted};
      5'd3:    return {30'b0, m_bp_en};
      5'd4:    return m_bp_addr[0];
      5'd5:    return m_bp_addr[1];
      5'd8:    return {27'b0, m_gpr_idx};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [31:0] wd,
                             output bit exp_res, output bit exp_step);
    exp_res = 0; exp_step = 0;
    case (a)
      5'd1: begin
        if (wd[0]) m_halt = 1;
        if (wd[1] || wd[2]) begin
          if (!core_halted) m_err = 1;
          else if (wd[1]) begin m_halt = 0; exp_res = 1; end
          else exp_step = 1;
        end
      end
      5'd2: begin
        if (wd[1]) m_bp = 0;
        if (wd[2]) m_err = 0;
      end
      5'd3: m_bp_en = wd[NBP-1:0];
      5'd4: m_bp_addr[0] = wd;
      5'd5: m_bp_addr[1] = wd;
      5'd8: m_gpr_idx = wd[IW-1:0];
      default: ;
    endcase
  endtask

  task automatic do_access(input bit wr, input logic [4:0] addr, input logic [31:0] wd,
                           input int hold, input bit hit, output logic [31:0] rd,
                           output int lat, output int dr, output int ds, output int dy);
    int r0, s0, y0;
    bit got;
    @(negedge memi_clk);
    r0 = resume_cnt; s0 = step_cnt; y0 = ready_cnt;
    unstable = 0;
    memi_sel = 1; memi_addr = addr; memi_wr_rd = wr; memi_wdata = wd; bp_hit = hit;
    lat = 0; got = 0; rd = '0;
    while (!got && lat < 2000) begin
      @(negedge memi_clk);
      lat++;
      bp_hit = 0;
      if (memi_ready) begin got = 1; rd = memi_rdata; end
    end
    check("ready_seen", got, 1);
    repeat (hold) @(negedge memi_clk);
    memi_sel = 0;
    @(negedge memi_clk);
    dr = resume_cnt - r0; ds = step_cnt - s0; dy = ready_cnt - y0;
  endtask

  // one memi access checked against the model
  task automatic acc(input bit wr, input logic [4:0] addr, input logic [31:0] wd,
                     input int ackd, input logic [31:0] cv, input int hold, input bit hit);
    logic [31:0] exp_rd, rd;
    int exp_lat, lat, dr, ds, dy;
    bit exp_res, exp_step, core_acc;
    string t;
    t = $sformatf("%s@%0d", wr ? "wr" : "rd", addr);
    exp_rd = 0; exp_lat = 1; exp_res = 0; exp_step = 0; core_acc = 0;
    ack_delay = ackd; core_reg_rdata = cv;
    if (addr == 5'd9) begin
      if (!core_halted) m_err = 1;
      else begin
        core_acc = 1;
        exp_lat = (ackd == 0) ? AT + 1 : ackd + 1;
        exp_rd  = (wr || ackd == 0) ? 32'h0 : cv;
        if (ackd == 0) m_err = 1;
      end
    end else if (!wr) exp_rd = model_read(addr);
    else model_write(addr, wd, exp_res, exp_step);
    if (hit) m_bp = 1;
    do_access(wr, addr, wd, hold, hit, rd, lat, dr, ds, dy);
    check({t, " rdata"}, rd, exp_rd);
    check({t, " latency"}, lat, exp_lat);
    check({t, " ready_count"}, dy, 1);
    check({t, " resume"}, dr, exp_res);
    check({t, " step"}, ds, exp_step);
    check({t, " halt_req"}, halt_req, m_halt);
    check({t, " bp_en"}, bp_en, m_bp_en);
    check({t, " bp_addr"}, bp_addr, {m_bp_addr[1], m_bp_addr[0]});
    if (core_acc) begin
      check({t, " req_len"}, last_req_len, (ackd == 0) ? AT : ackd);
      check({t, " core_idx"}, idx_seen, m_gpr_idx);
      check({t, " core_wr"}, wr_seen, wr);
      check({t, " core_wdata"}, wdata_seen, wr ? wd : 32'h0);
      check({t, " core_stable"}, unstable, 0);
    end
  endtask

  initial begin
    int rc;
    model_reset();
    repeat (3) @(negedge memi_clk);
    rst_n = 1;
    @(negedge memi_clk);
    check("rst memi_ready", memi_ready, 0);
    check("rst memi_rdata", memi_rdata, 0);
    check("rst halt_req", halt_req, 0);
    check("rst resume", resume_pulse, 0);
    check("rst step", step_pulse, 0);
    check("rst bp_en", bp_en, 0);
    check("rst bp_addr", bp_addr, 0);
    check("rst core_req", core_reg_req, 0);
    check("rst core_wr", core_reg_wr, 0);
    check("rst core_idx", core_reg_idx, 0);
    check("rst core_wdata", core_reg_wdata, 0);

    acc(0, 5'd0, 0, 0, 0, 0, 0);
    acc(1, 5'd5, 32'h8000_0040, 0, 0, 0, 0);
    acc(1, 5'd3, 32'h3, 0, 0, 0, 0);
    check("bp1 addr", bp_addr[63:32], 32'h8000_0040);
    check("bp en", bp_en, 2'b11);
    acc(0, 5'd5, 0, 0, 0, 0, 0);
    acc(1, 5'd3, 32'hFFFF_FFFF, 0, 0, 0, 0);
    acc(0, 5'd3, 0, 0, 0, 0, 0);

    acc(1, 5'd1, 32'h1, 0, 0, 0, 0);
    core_halted = 1;
    acc(1, 5'd1, 32'h6, 0, 0, 0, 0);
    acc(0, 5'd1, 0, 0, 0, 0, 0);

    acc(1, 5'd8, 32'h5, 0, 0, 0, 0);
    acc(0, 5'd9, 0, 3, 32'hDEAD_BEEF, 0, 0);
    acc(0, 5'd9, 0, 0, 32'h1234_5678, 0, 0);
    acc(0, 5'd2, 0, 0, 0, 0, 0);
    acc(1, 5'd2, 32'h4, 0, 0, 0, 0);
    acc(0, 5'd2, 0, 0, 0, 0, 0);
    acc(1, 5'd9, 32'hCAFE_F00D, 2, 0, 0, 0);

    acc(1, 5'd1, 32'h4, 0, 0, 4, 0);

    acc(0, 5'd3, 0, 0, 0, 0, 1);
    acc(1, 5'd2, 32'h2, 0, 0, 0, 1);
    acc(0, 5'd2, 0, 0, 0, 0, 0);
    acc(1, 5'd2, 32'h2, 0, 0, 0, 0);
    acc(0, 5'd2, 0, 0, 0, 0, 0);

    core_halted = 0;
    acc(1, 5'd1, 32'h2, 0, 0, 0, 0);
    acc(0, 5'd2, 0, 0, 0, 0, 0);
    acc(1, 5'd2, 32'h4, 0, 0, 0, 0);
    acc(0, 5'd9, 0, 0, 0, 0, 0);
    acc(0, 5'd2, 0, 0, 0, 0, 0);
    acc(1, 5'd12, 32'hFFFF_FFFF, 0, 0, 0, 0);
    acc(0, 5'd12, 0, 0, 0, 0, 0);
    acc(0, 5'd2, 0, 0, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      logic [4:0] a;
      logic [31:0] wd;
      bit w;
      int ad;
      if ($urandom_range(0, 3) == 0) core_halted = ~core_halted;
      a  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
      w  = 1'($urandom_range(0, 1));
      wd = (a == 5'd1 || a == 5'd2) ? 32'($urandom_range(0, 7)) : $urandom;
      ad = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
      acc(w, a, wd, ad, $urandom, $urandom_range(0, 2), ($urandom_range(0, 5) == 0));
    end

    core_halted = 1;
    ack_delay = 0;
    @(negedge memi_clk);
    memi_sel = 1; memi_addr = 5'd9; memi_wr_rd = 0;
    repeat (3) @(negedge memi_clk);
    check("midcore req_before", core_reg_req, 1);
    rc = ready_cnt;
    #2 rst_n = 0;
    #1;
    check("midcore req_after_rst", core_reg_req, 0);
    check("midcore ready_after_rst", memi_ready, 0);
    memi_sel = 0;
    repeat (3) @(negedge memi_clk);
    rst_n = 1;
    model_reset();
    repeat (3) @(negedge memi_clk);
    check("midcore no_ready", ready_cnt - rc, 0);
    check("midcore halt_req", halt_req, 0);
    acc(0, 5'd2, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
